// File: rtl/qc_cyclic_shifter.sv
// qc_cyclic_shifter
// Two-stage valid/ready cyclic shifter for QC-LDPC message vectors.
// Lane i of a beat (i < Z) receives input lane (i+SN) mod Z.
// Lanes at or above Z, and every lane of a beat with an illegal Z or SN, read as zero.
// Optional feature macro: QCS_REVERSE_EN adds in_dir. With in_dir=1 the beat is
// rotated the other way, so lane i receives input lane (i-SN) mod Z.
module qc_cyclic_shifter #(
    parameter int ZMAX = 96,
    parameter int DW   = 8,
    parameter int SW   = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ZMAX*DW-1:0]   in_data,
    input  logic [SW-1:0]        in_z,
    input  logic [SW-1:0]        in_sn,
`ifdef QCS_REVERSE_EN
    input  logic                 in_dir,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ZMAX*DW-1:0]   out_data,
    output logic                 out_err
);

    localparam int W = ZMAX * DW;
    localparam logic [SW-1:0] ZMAX_W = SW'(ZMAX);

    logic          s1_valid;
    logic [W-1:0]  s1_data;
    logic [SW-1:0] s1_z;
    logic [SW-1:0] s1_sn;
    logic          s1_err;
    logic          s1_dir;

    logic          s2_valid;
    logic [W-1:0]  s2_data;
    logic          s2_err;

    logic          s1_ready;
    logic          s2_ready;
    logic          accept;
    logic          in_err;
    logic          beat_dir;
    logic [W-1:0]  rotated;
    int            src;

`ifdef QCS_REVERSE_EN
    assign beat_dir = in_dir;
`else
    assign beat_dir = 1'b0;
`endif

    // A stage can take new content when it is empty or its content leaves this cycle.
    assign s2_ready = ~s2_valid | out_ready;
    assign s1_ready = ~s1_valid | s2_ready;
    assign in_ready = ~rst & s1_ready;
    assign accept   = in_valid & in_ready;

    // Z must lie in 1..ZMAX and SN in 0..Z-1. SN is never reduced modulo Z.
    assign in_err = (in_z == '0) | (in_z > ZMAX_W) | (in_sn >= in_z);

    // Stage 1 valid bit: refilled from the input whenever the slot frees up.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
        end
    end

    // Stage 1 payload loads only on an accepted beat, so idle X never enters.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_data <= in_data;
            s1_z    <= in_z;
            s1_sn   <= in_sn;
            s1_err  <= in_err;
            s1_dir  <= beat_dir;
        end
    end

    // Rotation of the stage-1 beat. Since SN < Z and i < Z, one conditional wrap suffices.
    always_comb begin
        rotated = '0;
        src     = 0;
        if (!s1_err) begin
            for (int i = 0; i < ZMAX; i++) begin
                if (i < int'(s1_z)) begin
                    if (s1_dir) begin
                        src = i - int'(s1_sn);
                        if (src < 0) begin
                            src = src + int'(s1_z);
                        end
                    end else begin
                        src = i + int'(s1_sn);
                        if (src >= int'(s1_z)) begin
                            src = src - int'(s1_z);
                        end
                    end
                    rotated[i*DW +: DW] = s1_data[src*DW +: DW];
                end
            end
        end
    end

    // Stage 2 holds the rotated result. It is frozen while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_err   <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= rotated;
                s2_err  <= s1_err;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_err   = s2_err;

endmodule

// File: tb/tb_qc_cyclic_shifter.sv
// tb_qc_cyclic_shifter
// Scoreboard bench for qc_cyclic_shifter.
// The driver pushes the expected result for each accepted beat.
// A negedge monitor pops and compares each emitted beat.
// Build with QCS_REVERSE_EN defined to also exercise the inverse rotation.
module tb_qc_cyclic_shifter;

    localparam int ZMAX = 96;
    localparam int DW   = 8;
    localparam int SW   = 7;
    localparam int W    = ZMAX * DW;

    typedef struct packed {
        logic [W-1:0] d;
        logic         e;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [SW-1:0] in_z;
    logic [SW-1:0] in_sn;
`ifdef QCS_REVERSE_EN
    logic          in_dir;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_err;

    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];

    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_data;
    logic          prev_err;
    logic          stall_run;

    qc_cyclic_shifter #(.ZMAX(ZMAX), .DW(DW), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_z      (in_z),
        .in_sn     (in_sn),
`ifdef QCS_REVERSE_EN
        .in_dir    (in_dir),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Reference rotation written with the modulo operator.
    function automatic logic [W-1:0] rot_model(input logic [W-1:0] d, input int z,
                                               input int sn, input bit dir);
        logic [W-1:0] r;
        int src;
        r = '0;
        if (z < 1 || z > ZMAX || sn >= z) return r;
        for (int i = 0; i < z; i++) begin
            src = dir ? ((i - sn + z) % z) : ((i + sn) % z);
            r[i*DW +: DW] = d[src*DW +: DW];
        end
        return r;
    endfunction

    function automatic logic err_model(input int z, input int sn);
        return (z < 1 || z > ZMAX || sn >= z);
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act,
                               input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present one beat, wait (bounded) for acceptance, then log its expected result.
    task automatic applyStimulus(input logic [W-1:0] d, input int z, input int sn,
                                 input bit dir, input logic [W-1:0] exp_d,
                                 input logic exp_e);
        bit   taken;
        exp_t e;
        taken    = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_z     = SW'(z);
        in_sn    = SW'(sn);
`ifdef QCS_REVERSE_EN
        in_dir   = dir;
`endif
        for (int c = 0; c < 200 && !taken; c++) begin
            @(negedge clk);
            if (in_ready) taken = 1'b1;
        end
        checkOutput("accept_timeout", W'(taken), W'(1));
        @(posedge clk);
        #1;
        if (taken) begin
            e.d = exp_d;
            e.e = exp_e;
            sb.push_back(e);
        end
        in_valid = 1'b0;
        in_data  = 'x;
        in_z     = 'x;
        in_sn    = 'x;
    endtask

    task automatic waitDrain();
        for (int c = 0; c < 200 && sb.size() != 0; c++) begin
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        checkOutput("drain", W'(sb.size()), W'(0));
    endtask

    // Monitor: handshake rule, stall stability and in-order scoreboard comparison.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
            checkOutput("in_ready_in_reset", W'(in_ready), W'(0));
        end else begin
            checkOutput("in_ready", W'(in_ready), W'(!(sb.size() == 2 && !out_ready)));
            if (prev_stall) begin
                checkOutput("stall_valid", W'(out_valid), W'(1));
                checkOutput("stall_data", out_data, prev_data);
                checkOutput("stall_err", W'(out_err), W'(prev_err));
            end
            if (out_valid) begin
                checkOutput("beat_expected", W'(sb.size() != 0), W'(1));
                if (out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    checkOutput("out_data", out_data, e.d);
                    checkOutput("out_err", W'(out_err), W'(e.e));
                end
            end
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data;
            prev_err   = out_err;
        end
    end

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] x;
        logic [W-1:0] abcd;
        logic [W-1:0] abcd_fwd;
        int           z;
        int           sn;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 'x;
        in_z      = 'x;
        in_sn     = 'x;
`ifdef QCS_REVERSE_EN
        in_dir    = 1'b0;
`endif
        out_ready = 1'b1;
        stall_run = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", W'(out_valid), W'(0));
        checkOutput("reset_out_data", out_data, '0);
        checkOutput("reset_out_err", W'(out_err), W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full-size rotation, lane k = k, Z=96, SN=5
        $display("[TB] full-size rotation");
        for (int k = 0; k < ZMAX; k++) begin
            d[k*DW +: DW] = DW'(k);
            x[k*DW +: DW] = (k < 91) ? DW'(k + 5) : DW'(k - 91);
        end
        applyStimulus(d, 96, 5, 1'b0, x, 1'b0);

        // Maximum shift: lane 0 takes lane 95
        for (int k = 0; k < ZMAX; k++) begin
            x[k*DW +: DW] = (k == 0) ? DW'(95) : DW'(k - 1);
        end
        applyStimulus(d, 96, 95, 1'b0, x, 1'b0);

        // Small Z: A,B,C,D -> B,C,D,A, other lanes zero
        abcd = '0;
        for (int k = 0; k < ZMAX; k++) abcd[k*DW +: DW] = 8'h55;
        abcd[0*DW +: DW] = 8'hA1;
        abcd[1*DW +: DW] = 8'hB2;
        abcd[2*DW +: DW] = 8'hC3;
        abcd[3*DW +: DW] = 8'hD4;
        abcd_fwd = '0;
        abcd_fwd[0*DW +: DW] = 8'hB2;
        abcd_fwd[1*DW +: DW] = 8'hC3;
        abcd_fwd[2*DW +: DW] = 8'hD4;
        abcd_fwd[3*DW +: DW] = 8'hA1;
        applyStimulus(abcd, 4, 1, 1'b0, abcd_fwd, 1'b0);

        // SN=0 on Z=4 passes lanes 0..3 through
        x = '0;
        x[0*DW +: DW] = 8'hA1;
        x[1*DW +: DW] = 8'hB2;
        x[2*DW +: DW] = 8'hC3;
        x[3*DW +: DW] = 8'hD4;
        applyStimulus(abcd, 4, 0, 1'b0, x, 1'b0);

        // Illegal beats interleaved with legal ones, order must be kept
        $display("[TB] illegal beats");
        applyStimulus(abcd, 10, 10, 1'b0, '0, 1'b1);
        x = '0;
        x[0*DW +: DW] = 8'hA1;
        applyStimulus(abcd, 1, 0, 1'b0, x, 1'b0);
        applyStimulus(abcd, 0, 0, 1'b0, '0, 1'b1);
        applyStimulus(abcd, 97, 3, 1'b0, '0, 1'b1);
        applyStimulus(abcd, 127, 0, 1'b0, '0, 1'b1);
        waitDrain();

        // Back-to-back beats with out_ready pattern 1,0,0,1
        $display("[TB] back-to-back with stalls");
        stall_run = 1'b1;
        fork
            begin
                for (int j = 0; j < 20; j++) begin
                    for (int k = 0; k < ZMAX; k++) d[k*DW +: DW] = DW'(j * 37 + k * 3);
                    z  = 1 + (j * 7) % ZMAX;
                    sn = (j * 13) % z;
                    if (j == 6) sn = z;
                    applyStimulus(d, z, sn, 1'b0, rot_model(d, z, sn, 1'b0), err_model(z, sn));
                end
                stall_run = 1'b0;
            end
            begin
                for (int c = 0; c < 1000 && stall_run; c++) begin
                    @(posedge clk);
                    #1;
                    out_ready = (c % 4 == 0) || (c % 4 == 3);
                end
            end
        join
        out_ready = 1'b1;
        waitDrain();

        // Reset with two beats in flight
        $display("[TB] mid-stream reset");
        out_ready = 1'b0;
        applyStimulus(abcd, 4, 1, 1'b0, abcd_fwd, 1'b0);
        applyStimulus(abcd, 4, 2, 1'b0, rot_model(abcd, 4, 2, 1'b0), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_valid", W'(out_valid), W'(0));
        checkOutput("post_reset_data", out_data, '0);
        checkOutput("post_reset_err", W'(out_err), W'(0));
        repeat (5) @(posedge clk);
        #1;
        applyStimulus(abcd, 4, 3, 1'b0, rot_model(abcd, 4, 3, 1'b0), 1'b0);
        waitDrain();

`ifdef QCS_REVERSE_EN
        // Inverse rotation: A,B,C,D -> D,A,B,C
        $display("[TB] reverse rotation");
        x = '0;
        x[0*DW +: DW] = 8'hD4;
        x[1*DW +: DW] = 8'hA1;
        x[2*DW +: DW] = 8'hB2;
        x[3*DW +: DW] = 8'hC3;
        applyStimulus(abcd, 4, 1, 1'b1, x, 1'b0);
        applyStimulus(abcd, 4, 1, 1'b0, abcd_fwd, 1'b0);
        applyStimulus(abcd, 4, 4, 1'b1, '0, 1'b1);
        applyStimulus(d, 96, 5, 1'b1, rot_model(d, 96, 5, 1'b1), 1'b0);
        waitDrain();
`endif

        repeat (10) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
